// File: rtl/avalon_mem_slave.sv
// avalon_mem_slave: Avalon-MM slave word memory with programmable wait states,
// byte-lane writes, a sticky error flag for illegal requests and a synchronous
// preload port used to load programs before the CPU is released.
module avalon_mem_slave #(
    parameter int          DEPTH       = 64,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic        waitrequest,
    output logic [31:0] readdata,
    input  logic        inst_input,
    input  logic [7:0]  inst_addr,
    input  logic [31:0] instruction,
    output logic        err
);

    localparam int          AW          = $clog2(DEPTH);
    localparam logic [31:0] DEPTH_W     = 32'(DEPTH);
    localparam logic [31:0] DEPTH_BYTES = 32'(DEPTH * 4);
    localparam logic [3:0]  WS_INIT     = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        ACK
    } state_t;

    state_t        state;
    logic [3:0]    cnt;
    logic [31:0]   mem [DEPTH];

    logic [31:0]   bus_offset;
    logic          bus_in_range;
    logic [AW-1:0] bus_idx;
    logic          commit;
    logic          bus_we;
    logic [31:0]   preload_word;
    logic          preload_in_range;
    logic          preload_we;
    logic          unused_bits;

    // An address below BASE_ADDR wraps to a huge offset, so one unsigned
    // compare covers both ends of the window (BASE_ADDR is DEPTH*4 aligned).
    assign bus_offset       = address - BASE_ADDR;
    assign bus_in_range     = (bus_offset < DEPTH_BYTES);
    assign bus_idx          = bus_offset[AW+1:2];
    assign commit           = (state == BUSY) && (cnt == 4'd0);
    assign bus_we           = commit && write && !read && bus_in_range;

    assign preload_word     = 32'(inst_addr[7:2]);
    assign preload_in_range = (preload_word < DEPTH_W);
    assign preload_we       = (state == IDLE) && inst_input && preload_in_range;

    assign unused_bits      = ^inst_addr[1:0];

    // The slave stalls any pending request except in the single ACK cycle.
    assign waitrequest = (read || write) && (state != ACK);

    // Memory array: preload writes in IDLE, lane-masked bus writes at commit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (preload_we) begin
            mem[preload_word[AW-1:0]] <= instruction;
        end else if (bus_we) begin
            for (int b = 0; b < 4; b++) begin
                if (byteenable[b]) begin
                    mem[bus_idx][8*b +: 8] <= writedata[8*b +: 8];
                end
            end
        end
    end

    // Transfer FSM: IDLE accepts, BUSY counts wait states and commits, ACK releases.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            readdata <= '0;
            err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (inst_input) begin
                        if (!preload_in_range) begin
                            err <= 1'b1;
                        end
                    end else if (read || write) begin
                        cnt   <= WS_INIT;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state <= ACK;
                        if (read && write) begin
                            readdata <= '0;
                            err      <= 1'b1;
                        end else if (!bus_in_range) begin
                            err <= 1'b1;
                            if (read) begin
                                readdata <= '0;
                            end
                        end else if (read) begin
                            readdata <= mem[bus_idx];
                        end
                    end
                end
                ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_avalon_mem_slave.sv
// tb_avalon_mem_slave: drives three slave instances (WAIT_STATES 1, 0 and 3)
// with a simple bus master; read data is predicted from a word model and
// queued on issue, then popped and compared when the slave acknowledges.
module tb_avalon_mem_slave;

    logic        clk;
    logic        reset;
    logic [31:0] address     [3];
    logic        read        [3];
    logic        write       [3];
    logic [31:0] writedata   [3];
    logic [3:0]  byteenable  [3];
    logic        waitrequest [3];
    logic [31:0] readdata    [3];
    logic        inst_input  [3];
    logic [7:0]  inst_addr   [3];
    logic [31:0] instruction [3];
    logic        err         [3];

    logic [31:0] model [3][64];
    logic        err_exp [3];
    logic [31:0] exp_q [$];

    int checks;
    int errors;
    int cycle_count;
    int ack_cycle;

    // Instance 0 uses WAIT_STATES=1, instance 1 uses 0, instance 2 uses 3.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        avalon_mem_slave #(
            .DEPTH       (64),
            .BASE_ADDR   (32'h0000_0000),
            .WAIT_STATES ((g == 0) ? 1 : ((g == 1) ? 0 : 3))
        ) dut (
            .clk         (clk),
            .reset       (reset),
            .address     (address[g]),
            .read        (read[g]),
            .write       (write[g]),
            .writedata   (writedata[g]),
            .byteenable  (byteenable[g]),
            .waitrequest (waitrequest[g]),
            .readdata    (readdata[g]),
            .inst_input  (inst_input[g]),
            .inst_addr   (inst_addr[g]),
            .instruction (instruction[g]),
            .err         (err[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running cycle counter used to measure acknowledge spacing.
    always @(posedge clk) cycle_count <= cycle_count + 1;

    function automatic int ws_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic clear_model();
        for (int d = 0; d < 3; d++) begin
            err_exp[d] = 1'b0;
            for (int i = 0; i < 64; i++) model[d][i] = '0;
        end
    endtask

    task automatic load_word(input int d, input logic [7:0] a, input logic [31:0] data);
        @(negedge clk);
        inst_input[d]  = 1'b1;
        inst_addr[d]   = a;
        instruction[d] = data;
        @(negedge clk);
        inst_input[d]  = 1'b0;
        model[d][a[7:2]] = data;
    endtask

    // One bus transfer; hold>0 keeps a preload to 0x20 active for that many cycles.
    task automatic applyStimulus(input int d, input bit rd, input bit wr,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] be, input int hold, input int exp_lat);
        int  cyc;
        bit  acked;
        bit  in_range;
        logic [31:0] exp_data;
        @(negedge clk);
        address[d]    = addr;
        read[d]       = rd;
        write[d]      = wr;
        writedata[d]  = wdata;
        byteenable[d] = be;
        if (hold > 0) begin
            inst_input[d]  = 1'b1;
            inst_addr[d]   = 8'h20;
            instruction[d] = 32'hCAFE_F00D;
            model[d][8]    = 32'hCAFE_F00D;
        end
        in_range = (addr < 32'h100);
        if (rd && wr) begin
            err_exp[d] = 1'b1;
            exp_q.push_back(32'h0);
        end else if (!in_range) begin
            err_exp[d] = 1'b1;
            if (rd) exp_q.push_back(32'h0);
        end else if (rd) begin
            exp_q.push_back(model[d][addr[7:2]]);
        end else if (wr) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) model[d][addr[7:2]][8*b +: 8] = wdata[8*b +: 8];
        end
        acked = 1'b0;
        cyc   = 0;
        while (!acked && cyc < 40) begin
            if (hold > 0 && cyc == hold) inst_input[d] = 1'b0;
            #1;
            if (!waitrequest[d]) begin
                acked     = 1'b1;
                ack_cycle = cycle_count;
                checkOutput("latency", 32'(cyc), 32'(exp_lat));
                if (rd) begin
                    exp_data = exp_q.pop_front();
                    checkOutput("readdata", readdata[d], exp_data);
                end
                checkOutput("err", 32'(err[d]), 32'(err_exp[d]));
                read[d]  = 1'b0;
                write[d] = 1'b0;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        if (!acked) begin
            checkOutput("ack_timeout", 32'(acked), 32'd1);
            if (rd && exp_q.size() > 0) exp_data = exp_q.pop_front();
            read[d]       = 1'b0;
            write[d]      = 1'b0;
            inst_input[d] = 1'b0;
        end
    endtask

    initial begin
        int prev;
        checks      = 0;
        errors      = 0;
        cycle_count = 0;
        ack_cycle   = 0;
        for (int d = 0; d < 3; d++) begin
            address[d] = '0; read[d] = 1'b0; write[d] = 1'b0;
            writedata[d] = '0; byteenable[d] = '0;
            inst_input[d] = 1'b0; inst_addr[d] = '0; instruction[d] = '0;
        end
        clear_model();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        checkOutput("rst_waitrequest", 32'(waitrequest[0]), 32'd0);
        checkOutput("rst_readdata", readdata[0], 32'h0);
        checkOutput("rst_err", 32'(err[0]), 32'd0);

        $display("[TB] preload and first read");
        load_word(0, 8'h04, 32'h2402_0090);
        load_word(0, 8'h08, 32'h2403_0050);
        applyStimulus(0, 1, 0, 32'h04, 32'h0, 4'h0, 0, 3);

        $display("[TB] byte-lane writes");
        applyStimulus(0, 0, 1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 3);
        applyStimulus(0, 0, 1, 32'h10, 32'h0000_0012, 4'h1, 0, 3);
        applyStimulus(0, 1, 0, 32'h10, 32'h0, 4'h0, 0, 3);
        applyStimulus(0, 0, 1, 32'h10, 32'hFFFF_FFFF, 4'h0, 0, 3);
        applyStimulus(0, 0, 1, 32'h14, 32'hA1B2_C3D4, 4'h6, 0, 3);
        applyStimulus(0, 1, 0, 32'h10, 32'h0, 4'h0, 0, 3);
        applyStimulus(0, 1, 0, 32'h14, 32'h0, 4'h0, 0, 3);

        $display("[TB] request held off by preload");
        applyStimulus(0, 1, 0, 32'h10, 32'h0, 4'h0, 3, 6);
        applyStimulus(0, 1, 0, 32'h20, 32'h0, 4'h0, 0, 3);

        $display("[TB] illegal requests");
        applyStimulus(0, 1, 0, 32'h100, 32'h0, 4'h0, 0, 3);
        applyStimulus(0, 1, 0, 32'h04, 32'h0, 4'h0, 0, 3);
        applyStimulus(0, 1, 1, 32'h00, 32'hFFFF_FFFF, 4'hF, 0, 3);
        applyStimulus(0, 0, 1, 32'h104, 32'h5555_5555, 4'hF, 0, 3);
        applyStimulus(0, 1, 0, 32'h00, 32'h0, 4'h0, 0, 3);

        $display("[TB] reset during a write");
        @(negedge clk);
        address[0] = 32'h0C; write[0] = 1'b1;
        writedata[0] = 32'h1111_1111; byteenable[0] = 4'hF;
        @(negedge clk);
        checkOutput("busy_waitrequest", 32'(waitrequest[0]), 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("reset_err", 32'(err[0]), 32'd0);
        write[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        clear_model();
        checkOutput("post_reset_waitrequest", 32'(waitrequest[0]), 32'd0);
        applyStimulus(0, 1, 0, 32'h0C, 32'h0, 4'h0, 0, 3);
        applyStimulus(0, 1, 0, 32'h04, 32'h0, 4'h0, 0, 3);

        $display("[TB] back-to-back reads");
        for (int d = 1; d < 3; d++) begin
            for (int i = 0; i < 4; i++)
                load_word(d, 8'(i * 4), 32'h1000_0000 + 32'(d * 32'h100) + 32'(i * 32'h11));
            prev = 0;
            for (int i = 0; i < 4; i++) begin
                applyStimulus(d, 1, 0, 32'(i * 4), 32'h0, 4'h0, 0, ws_of(d) + 2);
                if (i > 0) checkOutput("ack_spacing", 32'(ack_cycle - prev), 32'(ws_of(d) + 3));
                prev = ack_cycle;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
